updown_game_ctrl: RTL and testbench

Game sequencer for the up/down number-guessing design. It draws a target from the `random_num` generator and accepts player guesses, answering each with an up, down or correct hint. It counts attempts and ends the round on a win or when the try budget is exhausted. It sits between `random_num` (its `rnd` input) and the display/input logic.

---
 rtl/updown_game_ctrl.sv | 140 ++++++++++++++
 tb/tb_updown_game_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_game_ctrl.sv
// Up/down number-guessing sequencer: latches a target from random_num,
// grades player guesses and tracks attempts until win or try budget is spent.
module updown_game_ctrl #(
   parameter int unsigned MIN_VAL   = 1,
   parameter int unsigned MAX_VAL   = 99,
   parameter int unsigned MAX_TRIES = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] rnd,
   input  logic       guess_valid,
   input  logic [6:0] guess,
   output logic       guess_ready,
   output logic       result_valid,
   output logic       hint_up,
   output logic       hint_down,
   output logic       correct,
   output logic       invalid,
   output logic [3:0] attempts,
   output logic       win,
   output logic       lose,
   output logic [6:0] target
);

   localparam logic [6:0] MIN_V = MIN_VAL[6:0];
   localparam logic [6:0] MAX_V = MAX_VAL[6:0];
   localparam logic [3:0] TRIES = MAX_TRIES[3:0];

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PLAY,
      WIN,
      LOSE
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] target_q, target_d;
   logic [3:0] attempts_q, attempts_d;
   logic       hint_up_q, hint_up_d;
   logic       hint_down_q, hint_down_d;
   logic       correct_q, correct_d;
   logic       result_valid_q, result_valid_d;
   logic       invalid_q, invalid_d;

   logic       rnd_ok;
   logic       guess_ok;

   assign rnd_ok   = (rnd >= MIN_V) && (rnd <= MAX_V);
   assign guess_ok = (guess >= MIN_V) && (guess <= MAX_V);

   always_comb begin
      state_d        = state_q;
      target_d       = target_q;
      attempts_d     = attempts_q;
      hint_up_d      = hint_up_q;
      hint_down_d    = hint_down_q;
      correct_d      = correct_q;
      result_valid_d = 1'b0;
      invalid_d      = 1'b0;

      unique case (state_q)
         IDLE, WIN, LOSE: begin
            if (start) begin
               state_d     = LOAD;
               attempts_d  = '0;
               hint_up_d   = 1'b0;
               hint_down_d = 1'b0;
               correct_d   = 1'b0;
            end
         end
         LOAD: begin
            if (rnd_ok) begin
               target_d = rnd;
               state_d  = PLAY;
            end
         end
         PLAY: begin
            // a restart takes priority and drops any guess in the same cycle
            if (start) begin
               state_d     = LOAD;
               attempts_d  = '0;
               hint_up_d   = 1'b0;
               hint_down_d = 1'b0;
               correct_d   = 1'b0;
            end else if (guess_valid) begin
               if (!guess_ok) begin
                  invalid_d = 1'b1;
               end else begin
                  attempts_d     = attempts_q + 4'd1;
                  result_valid_d = 1'b1;
                  hint_up_d      = guess < target_q;
                  hint_down_d    = guess > target_q;
                  correct_d      = guess == target_q;
                  if (guess == target_q)
                     state_d = WIN;
                  else if (attempts_d == TRIES)
                     state_d = LOSE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         target_q       <= '0;
         attempts_q     <= '0;
         hint_up_q      <= 1'b0;
         hint_down_q    <= 1'b0;
         correct_q      <= 1'b0;
         result_valid_q <= 1'b0;
         invalid_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         attempts_q     <= attempts_d;
         hint_up_q      <= hint_up_d;
         hint_down_q    <= hint_down_d;
         correct_q      <= correct_d;
         result_valid_q <= result_valid_d;
         invalid_q      <= invalid_d;
      end
   end

   assign guess_ready  = (state_q == PLAY);
   assign win          = (state_q == WIN);
   assign lose         = (state_q == LOSE);
   assign target       = target_q;
   assign attempts     = attempts_q;
   assign hint_up      = hint_up_q;
   assign hint_down    = hint_down_q;
   assign correct      = correct_q;
   assign result_valid = result_valid_q;
   assign invalid      = invalid_q;

endmodule

// File: tb/tb_updown_game_ctrl.sv
// Directed bench for updown_game_ctrl with default parameters
// (range 1..99, ten tries).
module tb_updown_game_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic [6:0] rnd;
   logic       guess_valid;
   logic [6:0] guess;
   logic       guess_ready;
   logic       result_valid;
   logic       hint_up;
   logic       hint_down;
   logic       correct;
   logic       invalid;
   logic [3:0] attempts;
   logic       win;
   logic       lose;
   logic [6:0] target;

   int compared;
   int mismatched;

   updown_game_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .rnd          (rnd),
      .guess_valid  (guess_valid),
      .guess        (guess),
      .guess_ready  (guess_ready),
      .result_valid (result_valid),
      .hint_up      (hint_up),
      .hint_down    (hint_down),
      .correct      (correct),
      .invalid      (invalid),
      .attempts     (attempts),
      .win          (win),
      .lose         (lose),
      .target       (target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // flags packed as {gr,rv,up,down,correct,invalid,win,lose}
   function automatic logic [7:0] flags();
      return {guess_ready, result_valid, hint_up, hint_down,
              correct, invalid, win, lose};
   endfunction

   initial begin
      compared    = 0;
      mismatched  = 0;
      reset       = 1'b1;
      start       = 1'b0;
      rnd         = 7'd0;
      guess_valid = 1'b0;
      guess       = 7'd0;

      #2;
      chk("reset_flags", flags(), 8'h00);
      chk("reset_attempts", attempts, 0);
      chk("reset_target", target, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("idle_flags", flags(), 8'h00);

      // range rejection: 0 and 127 refused, 42 accepted
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("load_ready0", guess_ready, 0);
      tick();
      chk("rej0_ready", guess_ready, 0);
      rnd = 7'd127;
      tick();
      chk("rej127_ready", guess_ready, 0);
      rnd = 7'd42;
      tick();
      chk("load_target", target, 42);
      chk("load_ready", guess_ready, 1);
      chk("load_attempts", attempts, 0);

      // hint sequence 50, 30, 42
      guess_valid = 1'b1;
      guess = 7'd50;
      tick();
      chk("g50_flags", flags(), 8'b1101_0000);
      chk("g50_att", attempts, 1);
      guess = 7'd30;
      tick();
      chk("g30_flags", flags(), 8'b1110_0000);
      chk("g30_att", attempts, 2);
      guess = 7'd42;
      tick();
      chk("g42_flags", flags(), 8'b0100_1010);
      chk("g42_att", attempts, 3);
      guess_valid = 1'b0;
      tick();
      chk("win_hold", flags(), 8'b0000_1010);
      chk("win_hold_att", attempts, 3);

      // restart from WIN clears hints
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rst_win_flags", flags(), 8'h00);
      chk("rst_win_att", attempts, 0);
      tick();
      chk("replay_ready", guess_ready, 1);

      // invalid guesses 0 and 100
      guess_valid = 1'b1;
      guess = 7'd0;
      tick();
      chk("inv0_flags", flags(), 8'b1000_0100);
      chk("inv0_att", attempts, 0);
      guess = 7'd100;
      tick();
      chk("inv100_flags", flags(), 8'b1000_0100);
      chk("inv100_att", attempts, 0);
      guess_valid = 1'b0;
      tick();
      chk("inv_clear", flags(), 8'b1000_0000);

      // ten misses: lose
      guess_valid = 1'b1;
      guess = 7'd10;
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk("miss_flags", flags(), 8'b1110_0000);
         chk("miss_att", attempts, i);
      end
      tick();
      chk("lose_flags", flags(), 8'b0110_0001);
      chk("lose_att", attempts, 10);
      chk("lose_target", target, 42);
      guess_valid = 1'b0;
      tick();
      chk("lose_hold", flags(), 8'b0010_0001);

      // nine misses then correct on the last try
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("lt_ready", guess_ready, 1);
      guess_valid = 1'b1;
      guess = 7'd10;
      for (int i = 1; i <= 9; i++) tick();
      chk("lt_att9", attempts, 9);
      guess = 7'd42;
      tick();
      chk("lastwin_flags", flags(), 8'b0100_1010);
      chk("lastwin_att", attempts, 10);
      guess_valid = 1'b0;

      // start and a correct guess together: start wins
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      guess_valid = 1'b1;
      guess = 7'd42;
      tick();
      start = 1'b0;
      guess_valid = 1'b0;
      chk("race_flags", flags(), 8'h00);
      chk("race_att", attempts, 0);
      tick();
      chk("race_replay", guess_ready, 1);

      // async reset mid-round
      guess_valid = 1'b1;
      guess = 7'd60;
      tick();
      guess_valid = 1'b0;
      chk("mid_att", attempts, 1);
      chk("mid_down", hint_down, 1);
      reset = 1'b1;
      #1;
      chk("areset_flags", flags(), 8'h00);
      chk("areset_att", attempts, 0);
      chk("areset_target", target, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("areset_idle", guess_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
